// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button, timer and display bundle
// between the board-side logic and stopwatch_ctrl.
interface stopwatch_ctrl_if #(
  parameter int LAP_AW = 2
) ();
  logic              btn_start;
  logic              btn_lap;
  logic [7:0]        minute_in;
  logic [7:0]        second_in;
  logic [7:0]        ms10_in;
  logic [LAP_AW-1:0] lap_rd_idx;
  logic              run;
  logic              clear;
  logic [1:0]        state;
  logic [7:0]        disp_minute;
  logic [7:0]        disp_second;
  logic [7:0]        disp_ms10;
  logic [LAP_AW:0]   lap_count;
  logic              lap_full;
  logic [23:0]       lap_rd_time;

  modport master (
    output btn_start, btn_lap,
    output minute_in, second_in, ms10_in,
    output lap_rd_idx,
    input  run, clear, state,
    input  disp_minute, disp_second, disp_ms10,
    input  lap_count, lap_full, lap_rd_time
  );

  modport slave (
    input  btn_start, btn_lap,
    input  minute_in, second_in, ms10_in,
    input  lap_rd_idx,
    output run, clear, state,
    output disp_minute, disp_second, disp_ms10,
    output lap_count, lap_full, lap_rd_time
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced START/LAP buttons driving the
// IDLE/RUN/STOP/LAP sequencer, lap memory and display select.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LAP_DEPTH       = 4,
  parameter int LAP_AW          = 2
) (
  input logic             mclk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LAP_AW:0] DEPTH =
    (LAP_AW + 1)'(LAP_DEPTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;
  localparam logic [1:0] S_LAP  = 2'b11;

  // bit 0 = START, bit 1 = LAP
  logic [1:0]    raw;
  logic [1:0]    s1_q;
  logic [1:0]    s2_q;
  logic [1:0]    db_q;
  logic [1:0]    db_d;
  logic [1:0]    dbp_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    press;
  logic          start_p;
  logic          lap_p;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              run_q;
  logic              run_d;
  logic              clear_q;
  logic              clr;
  logic              cap;
  logic              wr;
  logic              full;
  logic [23:0]       live;
  logic [23:0]       disp_q;
  logic [23:0]       disp_d;
  logic [LAP_AW:0]   lap_count_q;
  logic [LAP_AW:0]   lap_count_d;
  logic [23:0]       mem_q [LAP_DEPTH];
  logic [23:0]       rd_time;

  assign raw  = {sw.btn_lap, sw.btn_start};
  assign live = {sw.minute_in, sw.second_in, sw.ms10_in};

  // Debounce: accept a new level after CNT_MAX+1 stable samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Two-flop synchronisers and debounce state
  always_ff @(posedge mclk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      dbp_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      dbp_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Rising edges only; START wins over a same-cycle LAP
  assign press   = db_q & ~dbp_q;
  assign start_p = press[0];
  assign lap_p   = press[1] & ~press[0];
  assign full    = (lap_count_q == DEPTH);

  // Sequencer next state, capture and clear decisions
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start_p) state_d = S_RUN;
      end
      (state_q == S_RUN): begin
        if (start_p) begin
          state_d = S_STOP;
        end else if (lap_p) begin
          cap     = 1'b1;
          state_d = S_LAP;
        end
      end
      (state_q == S_LAP): begin
        if (start_p) begin
          state_d = S_STOP;
        end else if (lap_p) begin
          cap = 1'b1;
        end
      end
      (state_q == S_STOP): begin
        if (start_p) begin
          state_d = S_RUN;
        end else if (lap_p) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Run level, display select and lap counter next values
  always_comb begin
    run_d  = (state_d == S_RUN) || (state_d == S_LAP);
    wr     = cap && !full;
    disp_d = live;
    if ((state_d == S_LAP) && !cap) begin
      disp_d = disp_q;
    end
    lap_count_d = lap_count_q;
    if (clr) begin
      lap_count_d = '0;
    end else if (wr) begin
      lap_count_d = lap_count_q + 1'b1;
    end
  end

  // Sequencer and display registers
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      clear_q     <= 1'b0;
      disp_q      <= '0;
      lap_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      clear_q     <= clr;
      disp_q      <= disp_d;
      lap_count_q <= lap_count_d;
    end
  end

  // Lap memory: zeroed on reset and on clear
  always_ff @(posedge mclk) begin
    if (reset || clr) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr) begin
      mem_q[lap_count_q[LAP_AW-1:0]] <= live;
    end
  end

  // Lap read: entries past lap_count read as zero
  always_comb begin
    rd_time = '0;
    if ({1'b0, sw.lap_rd_idx} < lap_count_q) begin
      rd_time = mem_q[sw.lap_rd_idx];
    end
  end

  assign sw.run         = run_q;
  assign sw.clear       = clear_q;
  assign sw.state       = state_q;
  assign sw.disp_minute = disp_q[23:16];
  assign sw.disp_second = disp_q[15:8];
  assign sw.disp_ms10   = disp_q[7:0];
  assign sw.lap_count   = lap_count_q;
  assign sw.lap_full    = full;
  assign sw.lap_rd_time = rd_time;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Button-driven sequencer for the stopwatch timer. It debounces the raw START and LAP buttons and runs the IDLE/RUN/STOP/LAP state machine. It drives the timer's run level and clear pulse, captures lap times into a small lap memory, and selects live or frozen time for the display path. It sits between the board buttons and the timer/display logic.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive stable mclk samples required to accept a button level change (sim: 4)
LAP_DEPTH, 4, number of stored lap entries (power of 2, 2..8)
LAP_AW, 2, lap index width = log2(LAP_DEPTH)

Ports:
mclk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_start  in  1  raw asynchronous START/STOP button, active-high
btn_lap  in  1  raw asynchronous LAP/CLEAR button, active-high
minute_in  in  8  live minute count from timer
second_in  in  8  live second count from timer
ms10_in  in  8  live 10 ms count from timer
lap_rd_idx  in  LAP_AW  lap memory read index
run  out  1  timer run enable (registered)
clear  out  1  one-cycle timer clear pulse (registered)
state  out  2  FSM state: IDLE=00, RUN=01, STOP=10, LAP=11
disp_minute  out  8  display minute (registered)
disp_second  out  8  display second (registered)
disp_ms10  out  8  display 10 ms (registered)
lap_count  out  LAP_AW+1  number of valid laps stored, 0..LAP_DEPTH
lap_full  out  1  lap_count == LAP_DEPTH
lap_rd_time  out  24  {minute, second, ms10} of entry lap_rd_idx; combinational read; all-zero if idx >= lap_count

Behaviour:
- Reset (mclk edge with reset=1): state=IDLE, run=0, clear=0, disp_*=0, lap_count=0, lap memory zeroed, sync flops, debounce counters, debounced levels and previous levels all 0. Reset wins over every other event in that cycle.
- Synchroniser: 2 flops per button (s1, s2).
- Debouncer, per button:
  - s2==db: cnt<=0.
  - s2!=db and cnt==DEBOUNCE_CYCLES-1: db<=s2, cnt<=0.
  - otherwise: cnt++.
  - press = db & ~db_prev, where db_prev is db registered.
  - Net latency: raw held high from before edge 1 means run/state/clear/capture update at edge DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press. Release generates no event.
- FSM (evaluated on press pulses; start_press has priority; a lap_press in the same cycle is discarded):
  - IDLE: run=0. start -> RUN. lap ignored.
  - RUN: run=1. start -> STOP. lap -> capture, go to LAP.
  - LAP: run=1, display frozen on last capture. lap -> capture again, stay LAP. start -> STOP.
  - STOP: run=0, display live (timer frozen). start -> RUN (resume, no clear). lap -> clear=1 for exactly one cycle, lap_count<=0, memory zeroed, go to IDLE.
- run is registered directly from next-state; it is 1 in RUN and LAP only.
- Capture: {minute_in, second_in, ms10_in} sampled on the press cycle is written to entry lap_count and lap_count increments.
  - When lap_full, the captured value still goes to the frozen display register, but memory and lap_count are unchanged (saturate, no wrap).
- Display:
  - LAP: disp_* = frozen capture register.
  - Any other state: disp_* <= live inputs (1-cycle latency).
  - Leaving LAP via start: display returns to live on the next edge.
- clear is 0 in all cycles except the STOP->IDLE transition edge. It is never asserted while run=1.

Test Plan:
- DEBOUNCE_CYCLES=4. After reset, raw btn_start high held 10 cycles -> run=1, state=01 exactly at edge 7; disp_* tracks inputs with 1-cycle lag.
- btn_start 3-cycle glitch in IDLE -> no state change, run stays 0. Button held 200 cycles -> exactly one transition.
- In RUN, inputs minute/second/ms10 = 1/23/45, press lap -> state=11, disp=01/17/2D hex, lap_count=1, lap_rd_time(idx 0)=0x01172D; inputs keep changing, disp constant. Press start -> state=10, run=0, disp live.
- Five lap presses with distinct inputs, LAP_DEPTH=4 -> lap_count=4, lap_full=1, entries 0..3 hold first four values, disp shows fifth.
- In STOP press lap -> clear high for one cycle, lap_count=0, all lap_rd_time=0, state=IDLE. Press start and lap in the same cycle while in RUN -> STOP, no capture.
- Assert reset mid-LAP with debounce counters nonzero -> all outputs at reset values next edge. A held button after reset release registers one press after DEBOUNCE_CYCLES+3 cycles.
